// File: rtl/multi_ch_decoder_pkg.sv
// Shared constants, opcode helpers and FSM states for the
// multi-channel command decoder.
package multi_ch_decoder_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [3:0] OP_OUT   = 4'h1;
  localparam logic [3:0] OP_FREQ  = 4'h2;
  localparam logic [3:0] OP_MODE  = 4'h3;
  localparam logic [3:0] OP_START = 4'h4;
  localparam logic [3:0] OP_STOP  = 4'h5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CHECK,
    S_COMMIT,
    S_ERR
  } state_t;

  function automatic logic op_ok(input logic [3:0] op);
    return (op >= OP_OUT) && (op <= OP_STOP);
  endfunction

  // Payload bytes carried by each opcode; nb is bytes per pattern.
  function automatic logic [3:0] op_len(
    input logic [3:0] op,
    input int         nb
  );
    logic [3:0] n;
    n = 4'd0;
    case (op)
      OP_OUT:  n = 4'(nb);
      OP_FREQ: n = 4'(nb);
      OP_MODE: n = 4'd1;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/multi_ch_decoder_timeout.sv
// Inter-byte timeout counter: clears on clr, counts while en,
// and holds once it reaches LIMIT-1.
module byte_timeout #(
  parameter int LIMIT = 20840,
  parameter int W     = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multi_ch_decoder.sv
// Framed UART command decoder driving CH_NUM channel controls.
// Optional trailing checksum byte enabled by CHECKSUM_EN.
module multi_ch_decoder
  import multi_ch_decoder_pkg::*;
#(
  parameter int DATA_BIT    = 16,
  parameter int CH_NUM      = 4,
  parameter int TIMEOUT_CLK = 20840,
  parameter int TO_BIT      = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 i_data,
  input  logic                       i_rx_done_tick,
  output logic [CH_NUM*DATA_BIT-1:0] o_output_pattern,
  output logic [CH_NUM*DATA_BIT-1:0] o_freq_pattern,
  output logic [CH_NUM-1:0]          o_mode,
  output logic [CH_NUM-1:0]          o_start,
  output logic [CH_NUM-1:0]          o_stop,
  output logic                       o_done_tick,
  output logic                       o_err_tick
);

  localparam int NB = DATA_BIT / 8;

`ifdef CHECKSUM_EN
  localparam state_t AFTER = S_CHECK;
`else
  localparam state_t AFTER = S_COMMIT;
`endif

  state_t              state;
  logic [7:0]          cmd;
  logic [7:0]          chk;
  logic [3:0]          len;
  logic [3:0]          cnt;
  logic [DATA_BIT-1:0] stage;
  logic [DATA_BIT+7:0] shifted;
  logic                to_clr;
  logic                to_en;
  logic                to_exp;
  logic                bad_ch;
  logic [3:0]          new_len;

  // LSB-first: each new byte enters at the top and drifts down.
  assign shifted = {i_data, stage};
  assign bad_ch  = {1'b0, i_data[7:4]} >= 5'(CH_NUM);
  assign new_len = op_len(i_data[3:0], NB);
  assign to_clr  = i_rx_done_tick || (state == S_IDLE);
  assign to_en   = (state == S_CMD) || (state == S_PAYLOAD)
                || (state == S_CHECK);

  byte_timeout #(
    .LIMIT (TIMEOUT_CLK),
    .W     (TO_BIT)
  ) u_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cmd              <= '0;
      chk              <= '0;
      len              <= '0;
      cnt              <= '0;
      stage            <= '0;
      o_output_pattern <= '0;
      o_freq_pattern   <= '0;
      o_mode           <= '0;
      o_start          <= '0;
      o_stop           <= '0;
      o_done_tick      <= 1'b0;
      o_err_tick       <= 1'b0;
    end else begin
      o_start     <= '0;
      o_stop      <= '0;
      o_done_tick <= 1'b0;
      o_err_tick  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_rx_done_tick && i_data == SYNC_BYTE) begin
            state <= S_CMD;
            cnt   <= '0;
            chk   <= '0;
            stage <= '0;
          end
        end
        S_CMD: begin
          if (i_rx_done_tick) begin
            cmd <= i_data;
            chk <= i_data;
            len <= new_len;
            if (bad_ch || !op_ok(i_data[3:0])) begin
              state <= S_ERR;
            end else if (new_len != 4'd0) begin
              state <= S_PAYLOAD;
            end else begin
              state <= AFTER;
            end
          end else if (to_exp) begin
            state <= S_ERR;
          end
        end
        S_PAYLOAD: begin
          if (i_rx_done_tick) begin
            stage <= shifted[DATA_BIT+7:8];
            chk   <= chk ^ i_data;
            cnt   <= cnt + 4'd1;
            if (cnt == len - 4'd1) begin
              state <= AFTER;
            end
          end else if (to_exp) begin
            state <= S_ERR;
          end
        end
        S_CHECK: begin
`ifdef CHECKSUM_EN
          if (i_rx_done_tick) begin
            state <= (i_data == chk) ? S_COMMIT : S_ERR;
          end else if (to_exp) begin
            state <= S_ERR;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_COMMIT: begin
          o_done_tick <= 1'b1;
          state       <= S_IDLE;
          for (int c = 0; c < CH_NUM; c++) begin
            if (cmd[7:4] == 4'(c)) begin
              unique case (1'b1)
                cmd[3:0] == OP_OUT:
                  o_output_pattern[c*DATA_BIT +: DATA_BIT] <= stage;
                cmd[3:0] == OP_FREQ:
                  o_freq_pattern[c*DATA_BIT +: DATA_BIT] <= stage;
                cmd[3:0] == OP_MODE:
                  o_mode[c] <= stage[DATA_BIT-8];
                cmd[3:0] == OP_START:
                  o_start[c] <= 1'b1;
                cmd[3:0] == OP_STOP:
                  o_stop[c] <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        S_ERR: begin
          o_err_tick <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ch_decoder.sv
// Directed bench for multi_ch_decoder (DATA_BIT=16, CH_NUM=4).
// Checksum scenarios follow CHECKSUM_EN when it is defined.
module tb_multi_ch_decoder;

  localparam int DB = 16;
  localparam int CN = 4;
  localparam int TO = 64;

  logic             clk;
  logic             rst_n;
  logic [7:0]       i_data;
  logic             i_rx_done_tick;
  logic [CN*DB-1:0] o_output_pattern;
  logic [CN*DB-1:0] o_freq_pattern;
  logic [CN-1:0]    o_mode;
  logic [CN-1:0]    o_start;
  logic [CN-1:0]    o_stop;
  logic             o_done_tick;
  logic             o_err_tick;

  int errors = 0;
  int checks = 0;
  int done_n = 0;
  int err_n  = 0;
  int done_w = 0;
  int err_w  = 0;
  logic [CN-1:0] start_acc = '0;
  logic [CN-1:0] stop_acc  = '0;
  logic          done_q    = 1'b0;
  logic          err_q     = 1'b0;
  logic [7:0]    fr[$];

  multi_ch_decoder #(
    .DATA_BIT    (DB),
    .CH_NUM      (CN),
    .TIMEOUT_CLK (TO),
    .TO_BIT      (7)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data           (i_data),
    .i_rx_done_tick   (i_rx_done_tick),
    .o_output_pattern (o_output_pattern),
    .o_freq_pattern   (o_freq_pattern),
    .o_mode           (o_mode),
    .o_start          (o_start),
    .o_stop           (o_stop),
    .o_done_tick      (o_done_tick),
    .o_err_tick       (o_err_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor; a second consecutive high sample marks a wide pulse.
  always @(negedge clk) begin
    if (o_done_tick) done_n++;
    if (o_err_tick) err_n++;
    if (o_done_tick && done_q) done_w++;
    if (o_err_tick && err_q) err_w++;
    start_acc = start_acc | o_start;
    stop_acc  = stop_acc | o_stop;
    done_q    = o_done_tick;
    err_q     = o_err_tick;
  end

  task automatic clr_mon();
    done_n = 0; err_n = 0; done_w = 0; err_w = 0;
    start_acc = '0; stop_acc = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_data = b;
    i_rx_done_tick = 1'b1;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    i_data = 8'h00;
  endtask

  // Append the trailing check byte when the build expects one.
  task automatic seal();
`ifdef CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
    fr.push_back(x);
`endif
  endtask

  task automatic send_fr();
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    idle(4);
  endtask

  task automatic test_reset();
    checks++;
    if (o_output_pattern !== '0) begin
      errors++;
      $display("FAIL rst_out: got %h want 0", o_output_pattern);
    end
    checks++;
    if (o_freq_pattern !== '0) begin
      errors++;
      $display("FAIL rst_freq: got %h want 0", o_freq_pattern);
    end
    checks++;
    if ({o_mode, o_start, o_stop, o_done_tick, o_err_tick} !== '0) begin
      errors++;
      $display("FAIL rst_ctl: mode %b start %b stop %b d %b e %b want 0",
               o_mode, o_start, o_stop, o_done_tick, o_err_tick);
    end
  endtask

  task automatic test_freq_write();
    clr_mon();
    fr = '{8'hA5, 8'h12, 8'h34, 8'h12};
    seal();
    for (int i = 0; i < fr.size() - 1; i++) send_byte(fr[i]);
    @(negedge clk);
    i_data = fr[fr.size()-1];
    i_rx_done_tick = 1'b1;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    checks++;
    if (o_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: done got %b want 0", o_done_tick);
    end
    @(negedge clk);
    checks++;
    if (o_done_tick !== 1'b1) begin
      errors++;
      $display("FAIL lat_done: done got %b want 1", o_done_tick);
    end
    checks++;
    if (o_freq_pattern !== 64'h0000_0000_1234_0000) begin
      errors++;
      $display("FAIL freq_ch1: got %h want 0000000012340000",
               o_freq_pattern);
    end
    idle(3);
    checks++;
    if (done_n !== 1 || done_w !== 0 || err_n !== 0) begin
      errors++;
      $display("FAIL freq_pulse: done %0d wide %0d err %0d want 1 0 0",
               done_n, done_w, err_n);
    end
    checks++;
    if (o_output_pattern !== '0) begin
      errors++;
      $display("FAIL freq_side: out got %h want 0", o_output_pattern);
    end
  endtask

  task automatic test_out_write();
    clr_mon();
    fr = '{8'hA5, 8'h21, 8'h34, 8'h12};
    seal();
    send_fr();
    checks++;
    if (o_output_pattern !== 64'h0000_1234_0000_0000) begin
      errors++;
      $display("FAIL out_ch2: got %h want 0000123400000000",
               o_output_pattern);
    end
    checks++;
    if (o_freq_pattern !== 64'h0000_0000_1234_0000) begin
      errors++;
      $display("FAIL out_side: freq got %h want 0000000012340000",
               o_freq_pattern);
    end
  endtask

  task automatic test_start_stop();
    clr_mon();
    fr = '{8'hA5, 8'h04};
    seal();
    send_fr();
    checks++;
    if (start_acc !== 4'b0001 || stop_acc !== 4'b0000) begin
      errors++;
      $display("FAIL start: start %b stop %b want 0001 0000",
               start_acc, stop_acc);
    end
    fr = '{8'hA5, 8'h35};
    seal();
    send_fr();
    checks++;
    if (stop_acc !== 4'b1000) begin
      errors++;
      $display("FAIL stop: got %b want 1000", stop_acc);
    end
    checks++;
    if (done_n !== 2 || done_w !== 0) begin
      errors++;
      $display("FAIL ss_done: count %0d wide %0d want 2 0",
               done_n, done_w);
    end
  endtask

  task automatic test_bad_cmd();
    clr_mon();
    fr = '{8'hA5, 8'h53, 8'h01};
    send_fr();
    checks++;
    if (err_n !== 1 || err_w !== 0 || done_n !== 0) begin
      errors++;
      $display("FAIL bad_ch: err %0d wide %0d done %0d want 1 0 0",
               err_n, err_w, done_n);
    end
    checks++;
    if (o_mode !== 4'b0000) begin
      errors++;
      $display("FAIL bad_ch_mode: got %b want 0000", o_mode);
    end
    clr_mon();
    fr = '{8'hA5, 8'h06};
    send_fr();
    checks++;
    if (err_n !== 1 || done_n !== 0) begin
      errors++;
      $display("FAIL bad_op: err %0d done %0d want 1 0", err_n, done_n);
    end
  endtask

  task automatic test_mode();
    clr_mon();
    send_byte(8'h77);
    fr = '{8'hA5, 8'h13, 8'h01};
    seal();
    send_fr();
    checks++;
    if (o_mode !== 4'b0010 || err_n !== 0) begin
      errors++;
      $display("FAIL mode_set: got %b err %0d want 0010 0", o_mode, err_n);
    end
    fr = '{8'hA5, 8'h13, 8'h00};
    seal();
    send_fr();
    checks++;
    if (o_mode !== 4'b0000) begin
      errors++;
      $display("FAIL mode_clr: got %b want 0000", o_mode);
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    clr_mon();
    fr = '{8'hA5, 8'h03, 8'h01, 8'h02};
    send_fr();
    checks++;
    if (o_mode !== 4'b0001 || done_n !== 1) begin
      errors++;
      $display("FAIL chk_ok: mode %b done %0d want 0001 1", o_mode, done_n);
    end
    clr_mon();
    fr = '{8'hA5, 8'h13, 8'h01, 8'h00};
    send_fr();
    checks++;
    if (o_mode !== 4'b0001 || err_n !== 1 || done_n !== 0) begin
      errors++;
      $display("FAIL chk_bad: mode %b err %0d done %0d want 0001 1 0",
               o_mode, err_n, done_n);
    end
  endtask
`endif

  task automatic test_timeout();
    int n;
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h21);
    send_byte(8'hAA);
    n = 0;
    while (err_n == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err_n !== 1 || n < TO - 10) begin
      errors++;
      $display("FAIL timeout: err %0d after %0d cycles want 1 after >=%0d",
               err_n, n, TO - 10);
    end
    checks++;
    if (o_output_pattern[2*DB +: DB] !== 16'h1234 || done_n !== 0) begin
      errors++;
      $display("FAIL to_keep: ch2 %h done %0d want 1234 0",
               o_output_pattern[2*DB +: DB], done_n);
    end
    fr = '{8'hA5, 8'h22, 8'hCD, 8'hAB};
    seal();
    send_fr();
    checks++;
    if (o_freq_pattern[2*DB +: DB] !== 16'hABCD || done_n !== 1) begin
      errors++;
      $display("FAIL to_next: ch2 freq %h done %0d want abcd 1",
               o_freq_pattern[2*DB +: DB], done_n);
    end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    fr = '{8'hA5, 8'h11, 8'hEF, 8'hBE};
    seal();
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    fr = '{8'hA5, 8'h31, 8'h34, 8'h12};
    seal();
    send_fr();
    checks++;
    if (o_output_pattern !== 64'h1234_1234_BEEF_0000) begin
      errors++;
      $display("FAIL b2b_out: got %h want 12341234beef0000",
               o_output_pattern);
    end
    checks++;
    if (done_n !== 2 || err_n !== 0) begin
      errors++;
      $display("FAIL b2b_done: done %0d err %0d want 2 0", done_n, err_n);
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h34);
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (o_output_pattern !== '0 || o_freq_pattern !== '0 ||
        o_mode !== '0) begin
      errors++;
      $display("FAIL rst_mid: out %h freq %h mode %b want 0",
               o_output_pattern, o_freq_pattern, o_mode);
    end
    rst_n = 1'b1;
    send_byte(8'h12);
    idle(6);
    checks++;
    if (err_n !== 0 || done_n !== 0 || o_output_pattern !== '0) begin
      errors++;
      $display("FAIL rst_after: err %0d done %0d out %h want 0 0 0",
               err_n, done_n, o_output_pattern);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_data = 8'h00;
    i_rx_done_tick = 1'b0;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_freq_write();
    test_out_write();
    test_start_stop();
    test_bad_cmd();
    test_mode();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
